// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the logic_unit_pipe slice: function-select encoding.
package logic_unit_pipe_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NAND   = 3'd2,
        OP_NOR    = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_IMPLY  = 3'd6,
        OP_NIMPLY = 3'd7
    } op_t;

endpackage

// File: rtl/logic_unit_pipe_logic_func.sv
// Combinational eight-way bitwise Boolean function of two WIDTH-bit operands.
module logic_func
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] s
);

    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        s = '0;
        unique case (op)
            OP_AND:    s = a & b;
            OP_OR:     s = a | b;
            OP_NAND:   s = ~(a & b);
            OP_NOR:    s = ~(a | b);
            OP_XOR:    s = a ^ b;
            OP_XNOR:   s = ~(a ^ b);
            OP_IMPLY:  s = ~a | b;
            OP_NIMPLY: s = a & ~b;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes and a packet
// accumulate mode that folds several beats into a single result.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               CNT_W    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] func_a;
    logic [WIDTH-1:0] func_s;
    logic             accept;

    // The output register can take a new beat whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign func_a   = in_acc ? acc_q : in_a;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    logic_func #(
        .WIDTH (WIDTH)
    ) u_func (
        .a  (func_a),
        .b  (in_b),
        .op (op_t'(in_op)),
        .s  (func_s)
    );

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_count <= '0;
            acc_q     <= ACC_INIT;
            cnt_q     <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A later assignment to out_valid overrides the pop, keeping it high on push+pop.
            if (accept) begin
                if (!in_acc) begin
                    out_s     <= func_s;
                    out_count <= CNT_W'(1);
                    out_valid <= 1'b1;
                end else if (!in_last) begin
                    acc_q <= func_s;
                    cnt_q <= cnt_inc;
                end else begin
                    out_s     <= func_s;
                    out_count <= cnt_inc;
                    out_valid <= 1'b1;
                    acc_q     <= ACC_INIT;
                    cnt_q     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_logic_unit_pipe;

    localparam int W     = 4;
    localparam int CW    = 4;
    localparam int C_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          in_acc;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_s;
    logic [CW-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one pending result slot plus the running packet.
    bit           m_valid;
    logic [W-1:0] m_s;
    int           m_count;
    logic [W-1:0] m_acc;
    int           m_cnt;

    always #5 clk = ~clk;

    logic_unit_pipe #(
        .WIDTH    (W),
        .CNT_W    (CW),
        .ACC_INIT ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_count (out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_f(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return ~(a & b);
            3:       return ~(a | b);
            4:       return a ^ b;
            5:       return ~(a ^ b);
            6:       return ~a | b;
            default: return a & ~b;
        endcase
    endfunction

    // Drives one cycle of inputs, advances the model across the edge, then
    // compares the DUT against the model at the following falling edge.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int op, input logic acc, input logic last, input logic ordy);
        bit take;
        rst = r; in_valid = v; in_a = a; in_b = b; in_op = 3'(op);
        in_acc = acc; in_last = last; out_ready = ordy;
        if (r) begin
            m_valid = 0; m_s = '0; m_count = 0; m_acc = '0; m_cnt = 0;
        end else begin
            take = v && (!m_valid || ordy);
            if (m_valid && ordy) m_valid = 0;
            if (take) begin
                if (!acc) begin
                    m_s = ref_f(op, a, b); m_count = 1; m_valid = 1;
                end else begin
                    m_acc = ref_f(op, m_acc, b);
                    m_cnt = (m_cnt + 1 > C_MAX) ? C_MAX : m_cnt + 1;
                    if (last) begin
                        m_s = m_acc; m_count = m_cnt; m_valid = 1;
                        m_acc = '0; m_cnt = 0;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        if (m_valid) begin
            check("out_s", 32'(out_s), 32'(m_s));
            check("out_count", 32'(out_count), 32'(m_count));
        end
    endtask

    initial begin
        logic [W-1:0] orv;
        logic [W-1:0] rb;
        rst = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_op = '0;
        in_acc = 0; in_last = 0; out_ready = 0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_s", 32'(out_s), 0);
        check("rst_count", 32'(out_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // All ops: a=0011, b=0101 covers every (a,b) bit pair per op
        for (int op = 0; op < 8; op++) begin
            cycle(0, 1, 4'b0011, 4'b0101, op, 0, 0, 1);
            check("op_count1", 32'(out_count), 1);
            if (op == 6) check("imply_tbl", 32'(out_s), 32'(4'b1101));
            if (op == 0) check("and_tbl", 32'(out_s), 32'(4'b0001));
        end

        // Back-to-back XOR throughput
        cycle(0, 1, 4'hA, 4'h5, 4, 0, 0, 1);
        check("xor0", 32'(out_s), 32'hF);
        cycle(0, 1, 4'hF, 4'h3, 4, 0, 0, 1);
        check("xor1", 32'(out_s), 32'hC);
        check("xor_rdy", 32'(in_ready), 1);
        cycle(0, 1, 4'h0, 4'h0, 4, 0, 0, 1);
        check("xor2", 32'(out_s), 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: second beat held while out_ready=0
        cycle(0, 1, 4'hC, 4'hA, 0, 0, 0, 1);
        check("bp_first", 32'(out_s), 32'h8);
        cycle(0, 1, 4'hF, 4'h3, 0, 0, 0, 0);
        check("bp_hold", 32'(out_s), 32'h8);
        check("bp_stall", 32'(in_ready), 0);
        cycle(0, 1, 4'hF, 4'h3, 0, 0, 0, 0);
        check("bp_hold2", 32'(out_s), 32'h8);
        cycle(0, 1, 4'hF, 4'h3, 0, 0, 0, 1);
        check("bp_second", 32'(out_s), 32'h3);
        check("bp_valid", 32'(out_valid), 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // Accumulate packet OR 1,4,8 then a fresh packet from acc=0
        cycle(0, 1, 4'hF, 4'h1, 1, 1, 0, 1);
        cycle(0, 1, 4'hF, 4'h4, 1, 1, 0, 1);
        check("acc_nooutput", 32'(out_valid), 0);
        cycle(0, 1, 4'hF, 4'h8, 1, 1, 1, 1);
        check("acc_s", 32'(out_s), 32'hD);
        check("acc_count", 32'(out_count), 3);
        cycle(0, 1, 4'h0, 4'h2, 1, 1, 1, 1);
        check("acc_fresh", 32'(out_s), 32'h2);
        check("acc_fresh_cnt", 32'(out_count), 1);

        // Saturation: 18-beat OR packet with a NOR beat inserted mid-packet
        orv = '0;
        for (int i = 0; i < 18; i++) begin
            rb = W'($urandom);
            orv |= rb;
            cycle(0, 1, 4'h0, rb, 1, 1, (i == 17), 1);
            if (i == 5) begin
                cycle(0, 1, 4'h0, 4'h0, 3, 0, 0, 1);
                check("mid_nor_s", 32'(out_s), 32'hF);
                check("mid_nor_cnt", 32'(out_count), 1);
            end
        end
        check("sat_s", 32'(out_s), 32'(orv));
        check("sat_count", 32'(out_count), 32'(C_MAX));

        // Reset mid-packet with an output pending
        cycle(0, 1, 4'h0, 4'h1, 1, 1, 0, 1);
        cycle(0, 1, 4'h0, 4'h2, 1, 1, 0, 1);
        cycle(0, 1, 4'hF, 4'hF, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("mr_valid", 32'(out_valid), 0);
        check("mr_s", 32'(out_s), 0);
        check("mr_count", 32'(out_count), 0);
        cycle(0, 1, 4'h0, 4'h2, 1, 1, 1, 1);
        check("mr_after_s", 32'(out_s), 32'h2);
        check("mr_after_cnt", 32'(out_count), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  W'($urandom), W'($urandom), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
